// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings
// and the default program counter value after reset.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_FETCH   = 2'd1,
    FETCH_DELIVER = 2'd2,
    FETCH_DRAIN   = 2'd3
  } fetch_state_e;

  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: branch load takes priority over increment;
// the increment wraps modulo 2^ADDR_W.
module fetch_pc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_load,
  input  logic [ADDR_W-1:0] I_load_val,
  input  logic              I_inc,
  output logic [ADDR_W-1:0] O_pc,
  output logic [ADDR_W-1:0] O_pc_next
);

  always_comb begin
    O_pc_next = O_pc;
    if (I_load)
      O_pc_next = I_load_val;
    else if (I_inc)
      O_pc_next = O_pc + ADDR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)
      O_pc <= ADDR_W'(RESET_PC);
    else
      O_pc <= O_pc_next;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory read port, valid/stall handoff
// to the decoder and branch redirect. Define FETCH_TIMEOUT_EN for the ack watchdog.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned INSTR_W        = 16,
  parameter int unsigned RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_enable,
  input  logic               I_stall,
  input  logic               I_branch,
  input  logic [ADDR_W-1:0]  I_branch_target,
  output logic [ADDR_W-1:0]  O_mem_addr,
  output logic               O_mem_req,
  input  logic               I_mem_ack,
  input  logic [INSTR_W-1:0] I_mem_data,
  output logic [INSTR_W-1:0] O_instruction,
  output logic               O_valid,
  output logic [ADDR_W-1:0]  O_pc,
  output logic               O_fault
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_next;
  logic              pc_inc;
  logic              capture;
  logic              timeout;
  logic              fault;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_load     (I_branch),
    .I_load_val (I_branch_target),
    .I_inc      (pc_inc),
    .O_pc       (pc_q),
    .O_pc_next  (pc_next)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            fault_q;

  // Counts consecutive ack-less cycles spent waiting on memory (FETCH or DRAIN).
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == FETCH_FETCH || state_q == FETCH_DRAIN) && !I_mem_ack)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign timeout = (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
  assign fault   = fault_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_q | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  assign O_fault = fault;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (I_enable && !fault)
          state_d = FETCH_FETCH;
      end
      FETCH_FETCH: begin
        if (I_mem_ack) begin
          if (I_branch) begin
            state_d = FETCH_FETCH;
          end else begin
            state_d = FETCH_DELIVER;
            capture = 1'b1;
            pc_inc  = 1'b1;
          end
        end else if (I_branch) begin
          // A request is never withdrawn before its ack; drain it instead.
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DELIVER: begin
        if (I_branch || !I_stall)
          state_d = I_enable ? FETCH_FETCH : FETCH_IDLE;
      end
      FETCH_DRAIN: begin
        if (I_mem_ack)
          state_d = I_enable ? FETCH_FETCH : FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (timeout)
      state_d = FETCH_IDLE;
  end

  // The read address has its own register so it stays stable through DRAIN
  // while the PC already holds the branch target.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= FETCH_IDLE;
      O_mem_req     <= 1'b0;
      O_mem_addr    <= ADDR_W'(RESET_PC);
      O_valid       <= 1'b0;
      O_instruction <= '0;
      O_pc          <= ADDR_W'(RESET_PC);
    end else begin
      state_q   <= state_d;
      O_mem_req <= (state_d == FETCH_FETCH) || (state_d == FETCH_DRAIN);
      O_valid   <= (state_d == FETCH_DELIVER);
      if (state_d == FETCH_FETCH)
        O_mem_addr <= pc_next;
      if (capture) begin
        O_instruction <= I_mem_data;
        O_pc          <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_fetch_unit;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  logic               I_clk = 1'b0;
  logic               I_rst_n;
  logic               I_enable;
  logic               I_stall;
  logic               I_branch;
  logic [ADDR_W-1:0]  I_branch_target;
  logic [ADDR_W-1:0]  O_mem_addr;
  logic               O_mem_req;
  logic               I_mem_ack;
  logic [INSTR_W-1:0] I_mem_data;
  logic [INSTR_W-1:0] O_instruction;
  logic               O_valid;
  logic [ADDR_W-1:0]  O_pc;
  logic               O_fault;

  fetch_unit #(
    .ADDR_W         (ADDR_W),
    .INSTR_W        (INSTR_W),
    .RESET_PC       (0),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .I_clk           (I_clk),
    .I_rst_n         (I_rst_n),
    .I_enable        (I_enable),
    .I_stall         (I_stall),
    .I_branch        (I_branch),
    .I_branch_target (I_branch_target),
    .O_mem_addr      (O_mem_addr),
    .O_mem_req       (O_mem_req),
    .I_mem_ack       (I_mem_ack),
    .I_mem_data      (I_mem_data),
    .O_instruction   (O_instruction),
    .O_valid         (O_valid),
    .O_pc            (O_pc),
    .O_fault         (O_fault)
  );

  always #5 I_clk = ~I_clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic model_on = 1'b1;
  logic [INSTR_W-1:0] mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the outstanding read, whether it will be dropped,
  // the held instruction and the address of the next fetch.
  logic              m_req, m_drop, m_valid;
  logic [ADDR_W-1:0] m_addr, m_next, m_opc;
  logic [INSTR_W-1:0] m_ins;

  always @(negedge I_clk) begin
    logic start;
    if (!I_rst_n || !model_on) begin
      m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
      m_addr = '0; m_next = '0; m_opc = '0; m_ins = '0;
    end else begin
      check("req", 32'(O_mem_req), 32'(m_req));
      check("valid", 32'(O_valid), 32'(m_valid));
      check("fault", 32'(O_fault), 0);
      if (m_req) check("addr", 32'(O_mem_addr), 32'(m_addr));
      if (m_valid) begin
        check("instr", 32'(O_instruction), 32'(m_ins));
        check("pc", 32'(O_pc), 32'(m_opc));
      end
      start = 1'b0;
      if (m_req) begin
        if (I_mem_ack) begin
          m_req = 1'b0;
          if (!m_drop && !I_branch) begin
            m_valid = 1'b1; m_ins = I_mem_data; m_opc = m_addr;
            m_next = m_addr + 8'd1;
          end else begin
            start = m_drop ? I_enable : 1'b1;
            if (I_branch) m_next = I_branch_target;
          end
        end else if (I_branch) begin
          m_drop = 1'b1; m_next = I_branch_target;
        end
      end else if (m_valid) begin
        if (I_branch) begin
          m_valid = 1'b0; m_next = I_branch_target; start = I_enable;
        end else if (!I_stall) begin
          m_valid = 1'b0; start = I_enable;
        end
      end else begin
        if (I_branch) m_next = I_branch_target;
        start = I_enable;
      end
      if (start) begin
        m_req = 1'b1; m_drop = 1'b0; m_addr = m_next;
      end
    end
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  // Wait (bounded) for a request, then ack it after lat further cycles.
  task automatic serve(input int lat);
    int n = 0;
    while (!O_mem_req && n < 50) begin tick(); n++; end
    check("req_wait", 32'(O_mem_req), 1);
    repeat (lat) tick();
    I_mem_ack  = 1'b1;
    I_mem_data = mem[O_mem_addr];
    tick();
    I_mem_ack  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A00;
    mem[0] = 16'h1234;
    I_rst_n = 1'b0; I_enable = 1'b0; I_stall = 1'b0; I_branch = 1'b0;
    I_branch_target = '0; I_mem_ack = 1'b0; I_mem_data = '0;
    #3;
    check("rst_req", 32'(O_mem_req), 0);
    check("rst_addr", 32'(O_mem_addr), 0);
    check("rst_valid", 32'(O_valid), 0);
    check("rst_instr", 32'(O_instruction), 0);
    check("rst_pc", 32'(O_pc), 0);
    check("rst_fault", 32'(O_fault), 0);
    tick();
    I_rst_n = 1'b1;
    tick();

    // Reset and first fetch, ack two cycles after the request.
    I_enable = 1'b1;
    tick();
    check("first_req", 32'(O_mem_req), 1);
    check("first_addr", 32'(O_mem_addr), 0);
    serve(2);
    check("first_valid", 32'(O_valid), 1);
    check("first_instr", 32'(O_instruction), 32'h1234);
    check("first_pc", 32'(O_pc), 0);
    tick();
    check("second_addr", 32'(O_mem_addr), 1);

    // Stall hold for three cycles in DELIVER.
    serve(1);
    I_stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_valid", 32'(O_valid), 1);
      check("stall_pc", 32'(O_pc), 1);
      check("stall_noreq", 32'(O_mem_req), 0);
    end
    I_stall = 1'b0;
    tick();
    check("after_stall_addr", 32'(O_mem_addr), 2);

    // Zero-wait fetches up to address 5, then branch while 5 waits.
    for (int a = 2; a < 5; a++) begin
      serve(0);
      tick();
    end
    tick();
    I_branch = 1'b1; I_branch_target = 8'h40;
    tick();
    I_branch = 1'b0;
    check("drain_req", 32'(O_mem_req), 1);
    check("drain_addr", 32'(O_mem_addr), 5);
    tick();
    I_mem_ack = 1'b1; I_mem_data = mem[5];
    tick();
    I_mem_ack = 1'b0;
    check("br_addr", 32'(O_mem_addr), 32'h40);
    check("br_novalid", 32'(O_valid), 0);
    serve(0);
    check("br_instr", 32'(O_instruction), 32'(mem[8'h40]));
    tick();

    // Branch in the same cycle as the ack: data discarded, refetch at target.
    I_mem_ack = 1'b1; I_mem_data = mem[8'h41];
    I_branch = 1'b1; I_branch_target = 8'hFE;
    tick();
    I_mem_ack = 1'b0; I_branch = 1'b0;
    check("ackbr_addr", 32'(O_mem_addr), 32'hFE);
    check("ackbr_novalid", 32'(O_valid), 0);

    // Wrap from 8'hFF to 8'h00.
    serve(0);
    tick();
    serve(1);
    check("wrap_pc", 32'(O_pc), 32'hFF);
    tick();
    check("wrap_addr", 32'(O_mem_addr), 0);

    // Branch in DELIVER beats a simultaneous stall.
    serve(0);
    I_branch = 1'b1; I_branch_target = 8'h80; I_stall = 1'b1;
    tick();
    I_branch = 1'b0; I_stall = 1'b0;
    check("dlvbr_addr", 32'(O_mem_addr), 32'h80);

    // Enable falls mid-fetch: the read completes and is delivered.
    I_enable = 1'b0;
    serve(2);
    check("endrop_valid", 32'(O_valid), 1);
    check("endrop_pc", 32'(O_pc), 32'h80);
    tick();
    check("endrop_idle", 32'(O_mem_req), 0);
    repeat (2) tick();

    // Branch while idle, then resume.
    I_branch = 1'b1; I_branch_target = 8'h10;
    tick();
    I_branch = 1'b0; I_enable = 1'b1;
    tick();
    check("idlebr_addr", 32'(O_mem_addr), 32'h10);

    // Asynchronous reset mid-fetch; a late ack must be ignored.
    #2;
    I_rst_n = 1'b0;
    #1;
    check("arst_req", 32'(O_mem_req), 0);
    check("arst_addr", 32'(O_mem_addr), 0);
    check("arst_valid", 32'(O_valid), 0);
    check("arst_instr", 32'(O_instruction), 0);
    check("arst_pc", 32'(O_pc), 0);
    I_mem_ack = 1'b1; I_mem_data = mem[8'h10];
    @(posedge I_clk);
    #1;
    I_enable = 1'b0; I_rst_n = 1'b1;
    tick();
    I_mem_ack = 1'b0;
    check("late_ack_valid", 32'(O_valid), 0);
    check("late_ack_req", 32'(O_mem_req), 0);
    I_enable = 1'b1;
    tick();
    check("restart_addr", 32'(O_mem_addr), 0);
    serve(0);
    tick();

`ifdef FETCH_TIMEOUT_EN
    // Never ack: the watchdog must trip and hold the unit idle.
    model_on = 1'b0;
    repeat (20) tick();
    check("to_fault", 32'(O_fault), 1);
    check("to_noreq", 32'(O_mem_req), 0);
    check("to_novalid", 32'(O_valid), 0);
    I_rst_n = 1'b0;
    tick();
    check("to_clear", 32'(O_fault), 0);
    I_rst_n = 1'b1;
    model_on = 1'b1;
    tick();
`endif

    I_enable = 1'b0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
